// File: rtl/rect_list_packer.sv
// Rectangle list producer: collects boxes into a shadow bank and publishes them at a frame boundary.
// Optional macro RECT_STALE_CLR_EN clears the published boxes after STALE_FRAMES frames without a commit.
`ifndef RECT_NUMMAX
`define RECT_NUMMAX 4
`endif

module rect_list_packer #(
   parameter int unsigned RECT_NUM     = `RECT_NUMMAX,
   parameter int unsigned CNT_W        = $clog2(RECT_NUM + 1),
   parameter int unsigned STALE_FRAMES = 4
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    i_vs,
   input  logic                    i_rect_valid,
   output logic                    o_rect_ready,
   input  logic                    i_rect_kind,
   input  logic [31:0]             i_rect_box,
   input  logic [63:0]             i_rect_posi,
   input  logic                    i_rect_last,
   output logic                    o_start,
   output logic [RECT_NUM*32-1:0]  o_head_wire,
   output logic [RECT_NUM*32-1:0]  o_hair_wire,
   output logic [RECT_NUM*64-1:0]  o_posi_wire,
   output logic [CNT_W-1:0]        o_head_cnt,
   output logic [CNT_W-1:0]        o_hair_cnt,
   output logic                    o_ovf
);

   typedef enum logic [1:0] {StFill, StPending, StCommit} state_t;

   state_t                   state;
   logic                     vs_d;
   logic                     vs_rise;
   logic [RECT_NUM*32-1:0]   sh_head;
   logic [RECT_NUM*32-1:0]   sh_hair;
   logic [RECT_NUM*64-1:0]   sh_posi;
   logic [CNT_W-1:0]         head_cnt;
   logic [CNT_W-1:0]         hair_cnt;

`ifdef RECT_STALE_CLR_EN
   localparam int unsigned SW = $clog2(STALE_FRAMES + 1);
   logic [SW-1:0] stale_cnt;
`endif

   assign vs_rise      = i_vs & ~vs_d;
   assign o_rect_ready = (state == StFill);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= StFill;
         vs_d        <= 1'b1;
         sh_head     <= '0;
         sh_hair     <= '0;
         sh_posi     <= '0;
         head_cnt    <= '0;
         hair_cnt    <= '0;
         o_start     <= 1'b0;
         o_ovf       <= 1'b0;
         o_head_wire <= '0;
         o_hair_wire <= '0;
         o_posi_wire <= '0;
         o_head_cnt  <= '0;
         o_hair_cnt  <= '0;
`ifdef RECT_STALE_CLR_EN
         stale_cnt   <= '0;
`endif
      end else begin
         vs_d    <= i_vs;
         o_start <= 1'b0;
         o_ovf   <= 1'b0;
         unique case (state)
            StFill: begin
               if (i_rect_valid) begin
                  if (!i_rect_kind) begin
                     if (head_cnt == CNT_W'(RECT_NUM)) begin
                        o_ovf <= 1'b1;
                     end else begin
                        for (int k = 0; k < RECT_NUM; k++) begin
                           if (CNT_W'(k) == head_cnt) begin
                              sh_head[k*32 +: 32] <= i_rect_box;
                              sh_posi[k*64 +: 64] <= i_rect_posi;
                           end
                        end
                        head_cnt <= head_cnt + CNT_W'(1);
                     end
                  end else begin
                     if (hair_cnt == CNT_W'(RECT_NUM)) begin
                        o_ovf <= 1'b1;
                     end else begin
                        for (int k = 0; k < RECT_NUM; k++) begin
                           if (CNT_W'(k) == hair_cnt) sh_hair[k*32 +: 32] <= i_rect_box;
                        end
                        hair_cnt <= hair_cnt + CNT_W'(1);
                     end
                  end
                  if (i_rect_last) state <= StPending;
               end
            end
            // A rise coinciding with the closing transfer is seen here in StFill and ignored.
            StPending: if (vs_rise) state <= StCommit;
            StCommit: begin
               o_head_wire <= sh_head;
               o_hair_wire <= sh_hair;
               o_posi_wire <= sh_posi;
               o_head_cnt  <= head_cnt;
               o_hair_cnt  <= hair_cnt;
               o_start     <= 1'b1;
               sh_head     <= '0;
               sh_hair     <= '0;
               sh_posi     <= '0;
               head_cnt    <= '0;
               hair_cnt    <= '0;
               state       <= StFill;
            end
            default: state <= StFill;
         endcase
`ifdef RECT_STALE_CLR_EN
         // A rise seen in StPending triggers a commit, so it does not age the display.
         if (state == StCommit) begin
            stale_cnt <= '0;
         end else if (vs_rise && state != StPending && stale_cnt < SW'(STALE_FRAMES)) begin
            stale_cnt <= stale_cnt + SW'(1);
            if (stale_cnt == SW'(STALE_FRAMES - 1)) begin
               o_head_wire <= '0;
               o_hair_wire <= '0;
               o_posi_wire <= '0;
               o_head_cnt  <= '0;
               o_hair_cnt  <= '0;
               o_start     <= 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_rect_list_packer.sv
// Scoreboard bench for rect_list_packer: a list-level model predicts each publish event and its cycle.
// Honours RECT_STALE_CLR_EN in the model when the macro is defined for the build.
module tb_rect_list_packer;

   localparam int N  = 4;
   localparam int CW = $clog2(N + 1);

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              i_vs = 1'b0, i_rect_valid = 1'b0, i_rect_kind = 1'b0, i_rect_last = 1'b0;
   logic [31:0]       i_rect_box = '0;
   logic [63:0]       i_rect_posi = '0;
   logic              o_rect_ready, o_start, o_ovf;
   logic [N*32-1:0]   o_head_wire, o_hair_wire;
   logic [N*64-1:0]   o_posi_wire;
   logic [CW-1:0]     o_head_cnt, o_hair_cnt;

   rect_list_packer #(.RECT_NUM(N), .STALE_FRAMES(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .i_vs(i_vs), .i_rect_valid(i_rect_valid),
      .o_rect_ready(o_rect_ready), .i_rect_kind(i_rect_kind), .i_rect_box(i_rect_box),
      .i_rect_posi(i_rect_posi), .i_rect_last(i_rect_last), .o_start(o_start),
      .o_head_wire(o_head_wire), .o_hair_wire(o_hair_wire), .o_posi_wire(o_posi_wire),
      .o_head_cnt(o_head_cnt), .o_hair_cnt(o_hair_cnt), .o_ovf(o_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [N*32-1:0] hw;
      logic [N*32-1:0] rw;
      logic [N*64-1:0] pw;
      int              hc;
      int              rc;
      longint          cyc;
   } exp_t;

   longint      cyc = 0;
   int          total = 0, bad = 0;
   int          ovf_exp = 0, ovf_seen = 0;
   exp_t        sbq[$];
   exp_t        cur_pub;
   logic [31:0] hq[$], rq[$];
   logic [63:0] hp[$];
   bit          m_pending = 0;
   int          fc = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N*64-1:0] act, input logic [N*64-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every o_start must match the oldest predicted publish, including its cycle.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (o_ovf) ovf_seen++;
         if (o_start) begin
            if (sbq.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("start_cycle", cyc, e.cyc);
               chk("head_wire", o_head_wire, e.hw);
               chk("hair_wire", o_hair_wire, e.rw);
               chk("posi_wire", o_posi_wire, e.pw);
               chk("head_cnt", o_head_cnt, e.hc);
               chk("hair_cnt", o_hair_cnt, e.rc);
            end
         end
      end
   end

   function automatic exp_t zero_pub(input longint c);
      exp_t e;
      e.hw = '0; e.rw = '0; e.pw = '0; e.hc = 0; e.rc = 0; e.cyc = c;
      return e;
   endfunction

   // Frame boundary seen by the model during cycle t.
   task automatic model_rise(input longint t);
      if (m_pending) begin
         exp_t e;
         e = zero_pub(t + 2);
         foreach (hq[k]) begin
            e.hw[k*32 +: 32] = hq[k];
            e.pw[k*64 +: 64] = hp[k];
         end
         foreach (rq[k]) e.rw[k*32 +: 32] = rq[k];
         e.hc = hq.size();
         e.rc = rq.size();
         sbq.push_back(e);
         cur_pub = e;
         hq.delete(); hp.delete(); rq.delete();
         m_pending = 0;
         fc = 0;
      end else begin
`ifdef RECT_STALE_CLR_EN
         if (fc < 4) begin
            fc++;
            if (fc == 4) begin
               cur_pub = zero_pub(t + 1);
               sbq.push_back(cur_pub);
            end
         end
`endif
      end
   endtask

   task automatic model_accept(input bit kind, input logic [31:0] box, input logic [63:0] posi,
                               input bit last);
      if (!kind) begin
         if (hq.size() < N) begin hq.push_back(box); hp.push_back(posi); end
         else ovf_exp++;
      end else begin
         if (rq.size() < N) rq.push_back(box);
         else ovf_exp++;
      end
      if (last) m_pending = 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   // Called 1 time unit after a rising edge; transfers one entry in the current cycle.
   task automatic push(input bit kind, input logic [31:0] box, input logic [63:0] posi,
                       input bit last, input bit with_vs);
      longint t;
      i_rect_valid = 1; i_rect_kind = kind; i_rect_box = box; i_rect_posi = posi;
      i_rect_last = last; i_vs = with_vs;
      t = cyc;
      @(negedge sys_clk);
      chk("ready_fill", o_rect_ready, 1);
      @(posedge sys_clk); #1;
      i_rect_valid = 0; i_rect_last = 0; i_vs = 0;
      if (with_vs) model_rise(t);
      model_accept(kind, box, posi, last);
   endtask

   task automatic vs_pulse();
      i_vs = 1;
      model_rise(cyc);
      idle(1);
      i_vs = 0;
      idle(3);
   endtask

   task automatic check_pub(input string name);
      chk({name, "_hw"}, o_head_wire, cur_pub.hw);
      chk({name, "_rw"}, o_hair_wire, cur_pub.rw);
      chk({name, "_pw"}, o_posi_wire, cur_pub.pw);
      chk({name, "_hc"}, o_head_cnt, cur_pub.hc);
      chk({name, "_rc"}, o_hair_cnt, cur_pub.rc);
   endtask

   int ovf_base;

   initial begin
      cur_pub = zero_pub(0);
      idle(3);
      sys_rst = 0;
      idle(2);
      // Reset state
      check_pub("reset");
      chk("reset_ready", o_rect_ready, 1);
      chk("reset_start", o_start, 0);

      // Single head + hair batch with known packing
      push(0, 32'h0A14323C, 64'h11, 0, 0);
      push(1, 32'h05050909, 64'hDEAD, 1, 0);
      idle(2);
      vs_pulse();
      chk("t1_head0", o_head_wire[31:0], 32'h0A14323C);
      chk("t1_hair0", o_hair_wire[31:0], 32'h05050909);
      chk("t1_posi0", o_posi_wire[63:0], 64'h11);
      chk("t1_cnts", {o_head_cnt, o_hair_cnt}, {CW'(1), CW'(1)});

      // Overflow: N+2 heads, two dropped
      ovf_base = ovf_seen;
      for (int i = 0; i < N + 2; i++) push(0, 32'h100 + i, 64'h200 + i, i == N + 1, 0);
      idle(2);
      chk("t2_ovf_pulses", ovf_seen - ovf_base, 2);
      vs_pulse();
      chk("t2_head_cnt", o_head_cnt, N);
      chk("t2_last_slot", o_head_wire[(N-1)*32 +: 32], 32'h100 + N - 1);

      // Closing transfer coincides with a frame rise: commit waits a frame
      push(1, 32'h31313131, 64'h0, 0, 0);
      push(0, 32'h32323232, 64'h5, 1, 1);
      idle(4);
      chk("t3_no_commit", o_head_cnt, N);
      vs_pulse();
      check_pub("t3_after");

      // Valid held through PENDING
      push(0, 32'h41414141, 64'h41, 1, 0);
      i_rect_valid = 1; i_rect_kind = 0; i_rect_box = 32'h4242AAAA; i_rect_posi = 64'h42;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk); chk("t4_ready_pend", o_rect_ready, 0);
         @(posedge sys_clk); #1;
      end
      i_vs = 1;
      model_rise(cyc);
      @(negedge sys_clk); chk("t4_ready_rise", o_rect_ready, 0);
      @(posedge sys_clk); #1; i_vs = 0;
      @(negedge sys_clk); chk("t4_ready_commit", o_rect_ready, 0);
      @(posedge sys_clk); #1;
      @(negedge sys_clk); chk("t4_ready_back", o_rect_ready, 1);
      @(posedge sys_clk); #1; i_rect_valid = 0;
      model_accept(0, 32'h4242AAAA, 64'h42, 0);
      push(1, 32'h43434343, 64'h0, 1, 0);
      idle(1);
      vs_pulse();
      chk("t4_slot0", o_head_wire[31:0], 32'h4242AAAA);

      // Reset while PENDING
      push(0, 32'h51, 64'h1, 0, 0);
      push(1, 32'h52, 64'h2, 0, 0);
      push(0, 32'h53, 64'h3, 1, 0);
      sys_rst = 1;
      hq.delete(); hp.delete(); rq.delete();
      m_pending = 0; fc = 0;
      cur_pub = zero_pub(0);
      idle(2);
      check_pub("t5_rst");
      chk("t5_pulses", {o_start, o_ovf}, 2'b00);
      sys_rst = 0;
      idle(2);
      vs_pulse();
      check_pub("t5_after");

      // Publish one box, then four empty frames
      push(0, 32'h61626364, 64'h66, 1, 0);
      idle(1);
      vs_pulse();
      for (int i = 0; i < 4; i++) vs_pulse();
      idle(2);
      check_pub("t6_stale");

      // Randomized batches with stray frame rises while filling
      for (int b = 0; b < 15; b++) begin
         int nh, nr, n;
         nh = $urandom_range(0, N + 2);
         nr = $urandom_range(0, N + 1);
         if (nh + nr == 0) nh = 1;
         n = nh + nr;
         for (int i = 0; i < n; i++) begin
            bit kind;
            if (nh == 0) kind = 1;
            else if (nr == 0) kind = 0;
            else kind = $urandom_range(0, 1);
            if (kind) nr--; else nh--;
            push(kind, $urandom | 32'h1, {$urandom, $urandom}, i == n - 1,
                 (i != n - 1) && ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
         idle($urandom_range(1, 3));
         vs_pulse();
         check_pub("rand_pub");
      end

      idle(4);
      chk("ovf_total", ovf_seen, ovf_exp);
      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
